// File: rtl/pcileech_sysctl.sv
// pcileech_sysctl: system reset, 64-bit tick counter, button debounce, LED stretchers and heartbeat
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   btn_in    in   raw asynchronous buttons, active-high
//   act_in    in   activity strobes from cores, active-high
//   rst       out  active-high system reset, released PARAM_RST_CYCLES+1 cycles after rst_n / reset-button release
//   tickcount out  free-running cycle counter, cleared only by rst_n
//   btn_db    out  debounced button levels
//   btn_rise  out  one-cycle pulse per debounced 0->1 edge
//   led_out   out  stretched activity LEDs, PARAM_LED_INVERT polarity applied
//   led_hb    out  heartbeat, tickcount[PARAM_HB_BIT]
// Optional macro PCILEECH_SYSCTL_PWM_EN: dims active LEDs and the heartbeat to tickcount[7:0] < PARAM_PWM_DUTY.
module pcileech_sysctl #(
  parameter int                 NUM_BTN               = 2,
  parameter int                 NUM_LED               = 2,
  parameter int                 PARAM_RST_CYCLES      = 64,
  parameter logic [NUM_BTN-1:0] PARAM_RST_BTN_MASK    = 'b01,
  parameter int                 PARAM_DEBOUNCE_CYCLES = 1000000,
  parameter int                 PARAM_STRETCH_CYCLES  = 5000000,
  parameter logic [NUM_LED-1:0] PARAM_LED_INVERT      = '0,
  parameter int                 PARAM_HB_BIT          = 26,
  parameter logic [7:0]         PARAM_PWM_DUTY        = 8'd255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_LED-1:0] act_in,
  output logic               rst,
  output logic [63:0]        tickcount,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_LED-1:0] led_out,
  output logic               led_hb
);
  localparam int DW = $clog2(PARAM_DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(PARAM_RST_CYCLES + 1);
  localparam int SW = $clog2(PARAM_STRETCH_CYCLES + 1);
`ifdef PCILEECH_SYSCTL_PWM_EN
  localparam logic PWM_EN = 1'b1;
`else
  localparam logic PWM_EN = 1'b0;
`endif
  typedef enum logic {HOLD, RUN} state_t;
  logic [63:0]        tick_q;
  logic [NUM_BTN-1:0] s1_q, s2_q, db_q, db_d, rise_q;
  logic [DW-1:0]      dcnt_q [NUM_BTN];
  logic [DW-1:0]      dcnt_d [NUM_BTN];
  logic [SW-1:0]      scnt_q [NUM_LED];
  logic [NUM_LED-1:0] act_v;
  logic [HW-1:0]      hold_q;
  state_t             st_q;
  logic               rst_q, btn_hit, pwm_on;
  // A counter reaching the threshold means DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      db_d[i]   = (s2_q[i] != db_q[i] && dcnt_q[i] == DW'(PARAM_DEBOUNCE_CYCLES)) ? s2_q[i] : db_q[i];
      dcnt_d[i] = (s2_q[i] == db_q[i] || dcnt_q[i] == DW'(PARAM_DEBOUNCE_CYCLES)) ? '0 : dcnt_q[i] + 1'b1;
    end
    for (int i = 0; i < NUM_LED; i++)
      act_v[i] = scnt_q[i] != '0;
  end
  assign btn_hit = |(db_q & PARAM_RST_BTN_MASK);
  // With dimming off the window is always open, so the duty value has no effect.
  assign pwm_on = ~PWM_EN | (tick_q[7:0] < PARAM_PWM_DUTY);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) dcnt_q[i] <= '0;
      for (int i = 0; i < NUM_LED; i++) scnt_q[i] <= '0;
    end else begin
      tick_q <= tick_q + 64'd1;
      s1_q   <= btn_in;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= db_d & ~db_q;
      for (int i = 0; i < NUM_BTN; i++) dcnt_q[i] <= dcnt_d[i];
      for (int i = 0; i < NUM_LED; i++)
        scnt_q[i] <= act_in[i] ? SW'(PARAM_STRETCH_CYCLES) : (act_v[i] ? scnt_q[i] - 1'b1 : scnt_q[i]);
    end
  end
  // Reset FSM: a held masked button pins the hold counter at 0 so the full hold restarts on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= HOLD;
      rst_q  <= 1'b1;
      hold_q <= '0;
    end else if (st_q == RUN) begin
      if (btn_hit) begin
        st_q   <= HOLD;
        rst_q  <= 1'b1;
        hold_q <= '0;
      end
    end else if (btn_hit) begin
      hold_q <= '0;
    end else if (hold_q == HW'(PARAM_RST_CYCLES)) begin
      st_q  <= RUN;
      rst_q <= 1'b0;
    end else begin
      hold_q <= hold_q + 1'b1;
    end
  end
  assign rst       = rst_q;
  assign tickcount = tick_q;
  assign btn_db    = db_q;
  assign btn_rise  = rise_q;
  assign led_out   = (act_v & {NUM_LED{pwm_on}}) ^ PARAM_LED_INVERT;
  assign led_hb    = tick_q[PARAM_HB_BIT] & pwm_on;
endmodule

// File: tb/tb_pcileech_sysctl.sv
// tb_pcileech_sysctl: randomized and directed checks of pcileech_sysctl against a cycle-level behavioural model
module tb_pcileech_sysctl;
  localparam int         RSTC = 64;
  localparam int         DEB  = 8;
  localparam int         STR  = 10;
  localparam int         HB   = 3;
  localparam logic [1:0] MASK = 2'b01;
  localparam logic [1:0] INV  = 2'b10;
  localparam logic [7:0] DUTY = 8'd64;
`ifdef PCILEECH_SYSCTL_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  btn_in = '0, act_in = '0;
  logic        rst, led_hb;
  logic [63:0] tickcount;
  logic [1:0]  btn_db, btn_rise, led_out;
  int checks = 0, fails = 0, rise0 = 0;
  logic [63:0] m_tick = '0;
  logic [1:0]  m_db = '0, m_rise = '0;
  int          m_quiet = 0;
  int          m_age [2] = '{1000, 1000};
  logic [1:0]  m_hist [$];

  pcileech_sysctl #(
    .NUM_BTN(2), .NUM_LED(2), .PARAM_RST_CYCLES(RSTC), .PARAM_RST_BTN_MASK(MASK),
    .PARAM_DEBOUNCE_CYCLES(DEB), .PARAM_STRETCH_CYCLES(STR), .PARAM_LED_INVERT(INV),
    .PARAM_HB_BIT(HB), .PARAM_PWM_DUTY(DUTY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .act_in(act_in), .rst(rst),
    .tickcount(tickcount), .btn_db(btn_db), .btn_rise(btn_rise), .led_out(led_out), .led_hb(led_hb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: a button level is accepted once DEB+1 consecutive synchronised samples
  // (raw samples two edges old) disagree with it; rst is high until RSTC+1 consecutive edges
  // have seen no masked debounced button; a channel is lit for STR cycles after its last strobe.
  task automatic model();
    logic [1:0] prev, s;
    bit flip;
    if (!rst_n) begin
      m_tick = '0; m_quiet = 0; m_db = '0; m_rise = '0;
      m_age[0] = 1000; m_age[1] = 1000;
      m_hist.delete();
      repeat (DEB + 3) m_hist.push_back(2'b00);
    end else begin
      m_tick++;
      m_quiet = |(m_db & MASK) ? 0 : (m_quiet < 1000 ? m_quiet + 1 : m_quiet);
      m_hist.push_back(btn_in);
      prev = m_db;
      for (int b = 0; b < 2; b++) begin
        flip = 1'b1;
        for (int k = 0; k <= DEB; k++) begin
          s = m_hist[m_hist.size() - 3 - k];
          if (s[b] == prev[b]) flip = 1'b0;
        end
        if (flip) m_db[b] = ~prev[b];
      end
      m_rise = m_db & ~prev;
      if (m_hist.size() > 40) void'(m_hist.pop_front());
      for (int i = 0; i < 2; i++)
        m_age[i] = act_in[i] ? 0 : (m_age[i] < 1000 ? m_age[i] + 1 : m_age[i]);
    end
  endtask

  task automatic step();
    logic pw;
    logic [1:0] el;
    @(posedge clk);
    model();
    #1;
    pw = PWM ? (m_tick[7:0] < DUTY) : 1'b1;
    for (int i = 0; i < 2; i++) el[i] = ((m_age[i] < STR) & pw) ^ INV[i];
    chk("tick", tickcount, m_tick);
    chk("rst", rst, (m_quiet <= RSTC));
    chk("btn_db", btn_db, m_db);
    chk("btn_rise", btn_rise, m_rise);
    chk("led_out", led_out, el);
    chk("led_hb", led_hb, m_tick[HB] & pw);
    if (btn_rise[0]) rise0++;
  endtask

  initial begin
    int n, on0, off1, dur [2];
    repeat (5) step();
    rst_n = 1'b1;
    for (n = 1; n < 200; n++) begin
      step();
      if (!rst) break;
    end
    chk("poweron_len", n, RSTC + 1);
    repeat (20) step();
    // Bounce rejection then settle high
    rise0 = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) btn_in[0] = ~btn_in[0];
      step();
    end
    btn_in[0] = 1'b1;
    for (n = 1; n < 60; n++) begin
      step();
      if (btn_db[0]) break;
    end
    chk("bounce_lat", n, 11);
    step();
    chk("rst_on_btn", rst, 1);
    repeat (90) step();
    chk("rise_count", rise0, 1);
    btn_in[0] = 1'b0;
    for (n = 1; n < 60; n++) begin
      step();
      if (!btn_db[0]) break;
    end
    for (n = 1; n < 200; n++) begin
      step();
      if (!rst) break;
    end
    chk("rst_release", n, RSTC + 1);
    // Stretch and retrigger
    repeat (20) step();
    on0 = 0; off1 = 0;
    act_in = 2'b11;
    step();
    if (led_out[0]) on0++;
    if (!led_out[1]) off1++;
    act_in = 2'b00;
    for (int c = 1; c < 30; c++) begin
      act_in[0] = (c == 5);
      step();
      if (led_out[0]) on0++;
      if (!led_out[1]) off1++;
    end
    act_in = 2'b00;
`ifndef PCILEECH_SYSCTL_PWM_EN
    chk("stretch0_len", on0, 15);
    chk("stretch1_len", off1, 10);
`endif
    // Reset while a stretch counter is at 7
    act_in[0] = 1'b1;
    step();
    act_in[0] = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midreset_led", led_out, INV);
    chk("midreset_db", btn_db, 2'b00);
    chk("midreset_rst", rst, 1);
    rst_n = 1'b1;
    // Randomized traffic
    dur[0] = 0; dur[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (dur[b] == 0) begin
          btn_in[b] = $urandom_range(0, 1) == 1;
          dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 120) : $urandom_range(1, 12);
        end
        dur[b]--;
      end
      act_in = {($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0)};
      rst_n = $urandom_range(0, 499) != 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
